// File: rtl/gpu_line_engine.sv
// Framebuffer line/clear engine: Bresenham line rasteriser and full-frame fill,
// writing one pixel per cycle into SRAM outside the display's active scan.
module gpu_line_engine #(
  parameter int H_RES   = 640,
  parameter int V_RES   = 400,
  parameter int COORD_W = 10,
  parameter int ADDR_W  = 18,
  parameter int DATA_W  = 16
) (
  input  logic               I_CLK,
  input  logic               I_RST_N,
  input  logic               I_VIDEO_ON,
  input  logic               I_CMD_VALID,
  output logic               O_CMD_READY,
  input  logic               I_CMD_OP,
  input  logic [COORD_W-1:0] I_CMD_X0,
  input  logic [COORD_W-1:0] I_CMD_Y0,
  input  logic [COORD_W-1:0] I_CMD_X1,
  input  logic [COORD_W-1:0] I_CMD_Y1,
  input  logic [DATA_W-1:0]  I_CMD_COLOR,
  output logic [ADDR_W-1:0]  O_GPU_ADDR,
  output logic [DATA_W-1:0]  O_GPU_DATA,
  output logic               O_GPU_WRITE,
  output logic               O_GPU_READ,
  output logic               O_BUSY,
  output logic [15:0]        O_PIX_COUNT
);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    DRAW,
    CLEAR
  } state_t;

  localparam int EW = COORD_W + 2;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(H_RES * V_RES - 1);
  localparam logic [ADDR_W-1:0] HRA  = ADDR_W'(H_RES);

  state_t state, state_nx;

  logic [COORD_W-1:0] x0, y0, x1, y1;
  logic [COORD_W-1:0] cur_x, cur_y;
  logic [DATA_W-1:0]  color;
  logic signed [EW-1:0] dx, dy, err;
  logic sx_neg, sy_neg;
  logic [ADDR_W-1:0] clr_addr;
  logic [15:0] pix_count;

  logic signed [EW-1:0] adx, ady, err_nx;
  logic signed [EW:0]   e2, dx_ext, dy_ext;
  logic step_x, step_y, in_range, at_end;
  logic [ADDR_W-1:0] pix_addr;
  logic [COORD_W-1:0] inc_x, inc_y;

  always_comb begin
    adx = (x1 >= x0) ? EW'(x1 - x0) : EW'(x0 - x1);
    ady = (y1 >= y0) ? EW'(y1 - y0) : EW'(y0 - y1);
  end

  // e2 carries one extra bit so 2*err never overflows
  assign e2     = {err, 1'b0};
  assign dx_ext = {dx[EW-1], dx};
  assign dy_ext = {dy[EW-1], dy};
  assign step_x = (e2 >= dy_ext);
  assign step_y = (e2 <= dx_ext);
  assign err_nx = err + (step_x ? dy : '0) + (step_y ? dx : '0);

  assign inc_x = sx_neg ? {COORD_W{1'b1}} : COORD_W'(1);
  assign inc_y = sy_neg ? {COORD_W{1'b1}} : COORD_W'(1);

  assign in_range = (32'(cur_x) < 32'(H_RES)) && (32'(cur_y) < 32'(V_RES));
  assign at_end   = (cur_x == x1) && (cur_y == y1);
  assign pix_addr = ADDR_W'(cur_y) * HRA + ADDR_W'(cur_x);

  always_comb begin
    state_nx    = state;
    O_GPU_ADDR  = '0;
    O_GPU_DATA  = '0;
    O_GPU_WRITE = 1'b0;
    unique case (state)
      IDLE: begin
        if (I_CMD_VALID)
          state_nx = I_CMD_OP ? CLEAR : SETUP;
      end
      SETUP: state_nx = DRAW;
      DRAW: begin
        O_GPU_ADDR = in_range ? pix_addr : '0;
        O_GPU_DATA = color;
        if (!I_VIDEO_ON) begin
          O_GPU_WRITE = in_range;
          if (at_end)
            state_nx = IDLE;
        end
      end
      CLEAR: begin
        O_GPU_ADDR = clr_addr;
        O_GPU_DATA = color;
        if (!I_VIDEO_ON) begin
          O_GPU_WRITE = 1'b1;
          if (clr_addr == LAST)
            state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign O_CMD_READY = (state == IDLE);
  assign O_BUSY      = (state != IDLE);
  assign O_GPU_READ  = 1'b0;
  assign O_PIX_COUNT = pix_count;

  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      state    <= IDLE;
      x0       <= '0;
      y0       <= '0;
      x1       <= '0;
      y1       <= '0;
      color    <= '0;
      cur_x    <= '0;
      cur_y    <= '0;
      dx       <= '0;
      dy       <= '0;
      err      <= '0;
      sx_neg   <= 1'b0;
      sy_neg   <= 1'b0;
      clr_addr <= '0;
    end else begin
      state <= state_nx;
      unique case (state)
        IDLE: begin
          if (I_CMD_VALID) begin
            x0       <= I_CMD_X0;
            y0       <= I_CMD_Y0;
            x1       <= I_CMD_X1;
            y1       <= I_CMD_Y1;
            color    <= I_CMD_COLOR;
            clr_addr <= '0;
          end
        end
        SETUP: begin
          dx     <= adx;
          dy     <= -ady;
          err    <= adx - ady;
          sx_neg <= (x1 < x0);
          sy_neg <= (y1 < y0);
          cur_x  <= x0;
          cur_y  <= y0;
        end
        DRAW: begin
          if (!I_VIDEO_ON && !at_end) begin
            err <= err_nx;
            if (step_x)
              cur_x <= cur_x + inc_x;
            if (step_y)
              cur_y <= cur_y + inc_y;
          end
        end
        CLEAR: begin
          if (!I_VIDEO_ON)
            clr_addr <= clr_addr + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N)
      pix_count <= '0;
    else if (O_GPU_WRITE && pix_count != 16'hFFFF)
      pix_count <= pix_count + 16'd1;
  end

endmodule

// File: tb/tb_gpu_line_engine.sv
// Bench for gpu_line_engine: directed and random lines against an integer
// line model, display stalls, busy-time commands, frame clear, async reset.
module tb_gpu_line_engine;

  localparam int H  = 640;
  localparam int V  = 16;
  localparam int CW = 10;
  localparam int AW = 18;
  localparam int DW = 16;
  localparam int NPIX = H * V;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic video_on = 1'b0;
  logic cmd_valid = 1'b0;
  logic cmd_op = 1'b0;
  logic [CW-1:0] cx0 = '0, cy0 = '0, cx1 = '0, cy1 = '0;
  logic [DW-1:0] ccolor = '0;
  logic cmd_ready, gpu_write, gpu_read, busy;
  logic [AW-1:0] gpu_addr;
  logic [DW-1:0] gpu_data;
  logic [15:0] pix_count;

  gpu_line_engine #(
    .H_RES(H), .V_RES(V), .COORD_W(CW), .ADDR_W(AW), .DATA_W(DW)
  ) dut (
    .I_CLK(clk),
    .I_RST_N(rst_n),
    .I_VIDEO_ON(video_on),
    .I_CMD_VALID(cmd_valid),
    .O_CMD_READY(cmd_ready),
    .I_CMD_OP(cmd_op),
    .I_CMD_X0(cx0),
    .I_CMD_Y0(cy0),
    .I_CMD_X1(cx1),
    .I_CMD_Y1(cy1),
    .I_CMD_COLOR(ccolor),
    .O_GPU_ADDR(gpu_addr),
    .O_GPU_DATA(gpu_data),
    .O_GPU_WRITE(gpu_write),
    .O_GPU_READ(gpu_read),
    .O_BUSY(busy),
    .O_PIX_COUNT(pix_count)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  logic [AW-1:0] got_a[$];
  logic [DW-1:0] got_d[$];
  int stall_writes = 0;

  int exp_a[$];
  int exp_pts;
  logic [AW-1:0] hold_a0, hold_a1;

  always @(negedge clk) begin
    if (rst_n && gpu_write) begin
      got_a.push_back(gpu_addr);
      got_d.push_back(gpu_data);
      if (video_on) stall_writes++;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: walk the line with the error-term rules in plain integers
  task automatic model_line(input int x0, input int y0, input int x1,
                            input int y1);
    int dx, dy, sx, sy, err, e2, x, y;
    exp_a.delete();
    exp_pts = 0;
    dx = (x1 > x0) ? x1 - x0 : x0 - x1;
    dy = -((y1 > y0) ? y1 - y0 : y0 - y1);
    sx = (x0 < x1) ? 1 : -1;
    sy = (y0 < y1) ? 1 : -1;
    err = dx + dy;
    x = x0;
    y = y0;
    forever begin
      exp_pts++;
      if (x < H && y < V) exp_a.push_back(y * H + x);
      if (x == x1 && y == y1) break;
      e2 = 2 * err;
      if (e2 >= dy) begin err += dy; x += sx; end
      if (e2 <= dx) begin err += dx; y += sy; end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one command and wait for completion; optional stall and busy poke
  task automatic run_cmd(input logic op, input int x0, input int y0,
                         input int x1, input int y1,
                         input logic [DW-1:0] col, input int stall_at,
                         input int stall_len, input int poke_at,
                         output int cyc);
    got_a.delete();
    got_d.delete();
    stall_writes = 0;
    cmd_valid = 1'b1;
    cmd_op = op;
    cx0 = CW'(x0);
    cy0 = CW'(y0);
    cx1 = CW'(x1);
    cy1 = CW'(y1);
    ccolor = col;
    step();
    cmd_valid = 1'b0;
    cyc = 0;
    while (busy && cyc < 30000) begin
      cyc++;
      cmd_valid = 1'b0;
      if (cyc == poke_at) begin
        cmd_valid = 1'b1;
        cmd_op = ~op;
        cx0 = '0;
        cy0 = '0;
      end
      if (cyc == stall_at) video_on = 1'b1;
      if (cyc == stall_at + stall_len) video_on = 1'b0;
      if (cyc == stall_at) hold_a0 = gpu_addr;
      if (cyc == stall_at + stall_len - 1) hold_a1 = gpu_addr;
      step();
    end
    cmd_valid = 1'b0;
    video_on = 1'b0;
    check("cmd_done", {63'd0, busy}, 64'd0);
  endtask

  task automatic compare_line(input string tag, input logic [DW-1:0] col);
    int bad;
    check({tag, "_nwrites"}, 64'(got_a.size()), 64'(exp_a.size()));
    bad = 0;
    for (int i = 0; i < got_a.size() && i < exp_a.size(); i++) begin
      if (got_a[i] !== AW'(exp_a[i]) || got_d[i] !== col) begin
        if (bad == 0)
          $display("  %s first diff @%0d addr=%0d want=%0d", tag, i,
                   got_a[i], exp_a[i]);
        bad++;
      end
    end
    check({tag, "_pixels"}, 64'(bad), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, pc0, bad;
    logic [DW-1:0] col;
    int rx0, ry0, rx1, ry1;

    repeat (3) step();
    check("rst_ready", {63'd0, cmd_ready}, 64'd1);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_write", {63'd0, gpu_write}, 64'd0);
    check("rst_read", {63'd0, gpu_read}, 64'd0);
    check("rst_addr", 64'(gpu_addr), 64'd0);
    check("rst_pix", 64'(pix_count), 64'd0);
    rst_n = 1'b1;
    step();

    model_line(10, 5, 14, 5);
    run_cmd(1'b0, 10, 5, 14, 5, 16'hF00F, -1, 0, -1, cyc);
    compare_line("hline", 16'hF00F);
    check("hline_first", 64'(got_a.size() > 0 ? got_a[0] : 0), 64'd3210);
    check("hline_busy", 64'(cyc), 64'(exp_pts + 1));
    check("hline_ready", {63'd0, cmd_ready}, 64'd1);
    check("hline_pix", 64'(pix_count), 64'd5);

    model_line(3, 10, 1, 4);
    run_cmd(1'b0, 3, 10, 1, 4, 16'h1234, -1, 0, -1, cyc);
    compare_line("steep", 16'h1234);
    check("steep_busy", 64'(cyc), 64'd8);

    pc0 = int'(pix_count);
    model_line(638, 0, 641, 0);
    run_cmd(1'b0, 638, 0, 641, 0, 16'h00AA, -1, 0, -1, cyc);
    compare_line("clip", 16'h00AA);
    check("clip_busy", 64'(cyc), 64'd5);
    check("clip_pix", 64'(int'(pix_count) - pc0), 64'd2);

    model_line(0, 2, 9, 7);
    run_cmd(1'b0, 0, 2, 9, 7, 16'hBEEF, 4, 3, -1, cyc);
    compare_line("stall", 16'hBEEF);
    check("stall_nowrite", 64'(stall_writes), 64'd0);
    check("stall_hold", 64'(hold_a1), 64'(hold_a0));
    check("stall_busy", 64'(cyc), 64'(exp_pts + 4));

    model_line(20, 1, 2, 9);
    run_cmd(1'b0, 20, 1, 2, 9, 16'h0F0F, -1, 0, 3, cyc);
    compare_line("poke", 16'h0F0F);
    repeat (3) step();
    check("poke_idle", {63'd0, busy}, 64'd0);

    model_line(5, 5, 5, 5);
    run_cmd(1'b0, 5, 5, 5, 5, 16'h7777, -1, 0, -1, cyc);
    compare_line("point", 16'h7777);
    check("point_busy", 64'(cyc), 64'd2);

    for (int n = 0; n < 24; n++) begin
      rx0 = int'($urandom_range(700));
      ry0 = int'($urandom_range(22));
      rx1 = int'($urandom_range(700));
      ry1 = int'($urandom_range(22));
      if (n % 3 == 0) rx1 = rx0 + int'($urandom_range(8));
      col = DW'($urandom);
      pc0 = int'(pix_count);
      model_line(rx0, ry0, rx1, ry1);
      run_cmd(1'b0, rx0, ry0, rx1, ry1, col, -1, 0, -1, cyc);
      compare_line($sformatf("rnd%0d", n), col);
      check($sformatf("rnd%0d_busy", n), 64'(cyc), 64'(exp_pts + 1));
      check($sformatf("rnd%0d_pix", n), 64'(int'(pix_count) - pc0),
            64'(exp_a.size()));
    end

    run_cmd(1'b1, 0, 0, 0, 0, 16'h0000, -1, 0, -1, cyc);
    check("clr_n", 64'(got_a.size()), 64'(NPIX));
    check("clr_last", 64'(got_a.size() > 0 ? got_a[$] : 0), 64'(NPIX - 1));
    check("clr_busy", 64'(cyc), 64'(NPIX));
    bad = 0;
    for (int i = 0; i < got_a.size(); i++)
      if (got_a[i] !== AW'(i) || got_d[i] !== 16'h0000) bad++;
    check("clr_seq", 64'(bad), 64'd0);
    check("clr_ready", {63'd0, cmd_ready}, 64'd1);

    got_a.delete();
    got_d.delete();
    cmd_valid = 1'b1;
    cmd_op = 1'b1;
    ccolor = 16'h5A3C;
    step();
    cmd_valid = 1'b0;
    repeat (100) step();
    check("mid_busy", {63'd0, busy}, 64'd1);
    bad = 0;
    for (int i = 0; i < got_a.size(); i++)
      if (got_a[i] !== AW'(i) || got_d[i] !== 16'h5A3C) bad++;
    check("mid_seq", 64'(bad), 64'd0);
    check("mid_n", 64'(got_a.size()), 64'd100);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_addr", 64'(gpu_addr), 64'd0);
    check("arst_data", 64'(gpu_data), 64'd0);
    check("arst_write", {63'd0, gpu_write}, 64'd0);
    check("arst_read", {63'd0, gpu_read}, 64'd0);
    check("arst_ready", {63'd0, cmd_ready}, 64'd1);
    check("arst_busy", {63'd0, busy}, 64'd0);
    check("arst_pix", 64'(pix_count), 64'd0);
    step();
    rst_n = 1'b1;
    repeat (2) step();
    check("post_ready", {63'd0, cmd_ready}, 64'd1);
    check("post_write", {63'd0, gpu_write}, 64'd0);

    model_line(1, 1, 4, 3);
    run_cmd(1'b0, 1, 1, 4, 3, 16'hC0DE, -1, 0, -1, cyc);
    compare_line("after_rst", 16'hC0DE);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/gpu_line_engine.md
GPU_LINE_ENGINE -- requirements
Module: gpu_line_engine

Interface
REQ-001 SHALL have parameter H_RES, default 640, meaning frame width in pixels.
REQ-002 SHALL have parameter V_RES, default 400, meaning frame height in pixels.
REQ-003 SHALL have parameter COORD_W, default 10, meaning coordinate width in bits.
REQ-004 SHALL have parameter ADDR_W, default 18, meaning SRAM address width; H_RES*V_RES <= 2^ADDR_W.
REQ-005 SHALL have parameter DATA_W, default 16, meaning pixel/colour width.
REQ-006 SHALL have port I_CLK, input, 1, sole clock; all logic on rising edge.
REQ-007 SHALL have port I_RST_N, input, 1; reset is asynchronous and active-low.
REQ-008 SHALL have port I_VIDEO_ON, input, 1; high = display scanning, so the engine must not write.
REQ-009 SHALL have port I_CMD_VALID, input, 1, command offered.
REQ-010 SHALL have port O_CMD_READY, output, 1, engine can accept a command.
REQ-011 SHALL have port I_CMD_OP, input, 1, 0 = line, 1 = clear.
REQ-012 SHALL have ports I_CMD_X0, I_CMD_Y0, I_CMD_X1, I_CMD_Y1, input, COORD_W each, unsigned endpoints.
REQ-013 SHALL have port I_CMD_COLOR, input, DATA_W, pixel value.
REQ-014 SHALL have port O_GPU_ADDR, output, ADDR_W, SRAM address.
REQ-015 SHALL have port O_GPU_DATA, output, DATA_W, SRAM write data.
REQ-016 SHALL have port O_GPU_WRITE, output, 1, SRAM write strobe.
REQ-017 SHALL have port O_GPU_READ, output, 1, always 0.
REQ-018 SHALL have port O_BUSY, output, 1, command in progress.
REQ-019 SHALL have port O_PIX_COUNT, output, 16, write strobes issued since reset.

Function
REQ-020 SHALL implement states IDLE, SETUP, DRAW, CLEAR; O_CMD_READY = 1 only in IDLE, O_BUSY = (state != IDLE).
REQ-021 SHALL accept a command on I_CMD_VALID & O_CMD_READY, latch all command fields, go to SETUP for op 0 or CLEAR for op 1.
REQ-022 SETUP SHALL last one cycle: dx=|X1-X0|, dy=-|Y1-Y0|, sx/sy=+1 or -1 by direction, err=dx+dy, signed COORD_W+2 bits; cur=(X0,Y0).
REQ-023 DRAW SHALL, per unstalled cycle, emit cur: if cur.x<H_RES and cur.y<V_RES then WRITE=1, ADDR=cur.y*H_RES+cur.x, DATA=colour; otherwise WRITE=0 (clipped).
REQ-024 DRAW SHALL step with e2=2*err: if e2>=dy then err+=dy, x+=sx; if e2<=dx then err+=dx, y+=sy; both applied in one cycle when both hold.
REQ-025 DRAW SHALL go to IDLE on the cycle it emits cur==(X1,Y1); line emits exactly max(|dx|,|dy|)+1 points, all octants.
REQ-026 Degenerate line (X0,Y0)==(X1,Y1) SHALL emit exactly one point.
REQ-027 CLEAR SHALL write ADDR 0..H_RES*V_RES-1, one per unstalled cycle, DATA=colour, then go to IDLE.
REQ-028 While I_VIDEO_ON=1 in DRAW or CLEAR, the engine SHALL hold state, hold ADDR/DATA, and drive WRITE=0; it resumes at the same pixel.
REQ-029 In IDLE and SETUP, WRITE SHALL be 0.
REQ-030 O_PIX_COUNT SHALL increment per WRITE=1 cycle and saturate at 16'hFFFF.
REQ-031 Command inputs SHALL be ignored while busy, with no queueing.

Reset
REQ-032 On I_RST_N low, immediately and including mid-command: state IDLE, ADDR 0, DATA 0, WRITE 0, READ 0, READY 1, BUSY 0, PIX_COUNT 0; the pending command is discarded.

Verification
REQ-033 Line (10,5)->(14,5), colour F00F -> five writes, ADDR 3210..3214, then READY=1.
REQ-034 Line (3,10)->(1,4) -> writes (3,10),(3,9),(2,8),(2,7),(2,6),(1,5),(1,4) in order.
REQ-035 I_VIDEO_ON high 3 cycles mid-line -> no writes for those cycles, then the same pixel is written again and the sequence continues.
REQ-036 Line (638,0)->(641,0) -> 4 DRAW cycles, writes only ADDR 638 and 639, PIX_COUNT +2.
REQ-037 Clear with colour 0 -> 256000 writes, last ADDR 255999, then IDLE.
REQ-038 Reset asserted mid-clear -> all outputs at reset values at once; READY=1 after release.
